ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences one instance of the team's dual-port RAM (WIDTH x DEPTH, registered 1-cycle read) as a circular buffer. It owns the write and read pointers, occupancy count, status flags and sticky error flags. It drives the RAM write and read ports, with both RAM clocks tied to i_clk. It presents a valid/enable streaming interface to producer and consumer logic.

Parameters:
WIDTH, 8, data word width; must match the RAM instance.
DEPTH, 256, number of entries; power of two, >= 4; must match the RAM instance.
AF_LEVEL, DEPTH-4, almost-full threshold; o_af when count >= AF_LEVEL; range 1..DEPTH.
AE_LEVEL, 4, almost-empty threshold; o_ae when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
i_clk  in  1  single clock for controller and both RAM ports
i_rst_n  in  1  asynchronous active-low reset
i_wr_dv  in  1  producer write request
i_wr_data  in  WIDTH  producer write data
i_rd_en  in  1  consumer read request
o_rd_data  out  WIDTH  read data, valid when o_rd_dv=1; wired from i_ram_rd_data
o_rd_dv  out  1  read data valid
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_af  out  1  almost full
o_ae  out  1  almost empty
o_count  out  $clog2(DEPTH)+1  current occupancy
o_overflow  out  1  sticky: write requested while full
o_underflow  out  1  sticky: read requested while empty
o_ram_wr_dv  out  1  to RAM i_wr_dv
o_ram_wr_addr  out  $clog2(DEPTH)  to RAM i_wr_addr
o_ram_wr_data  out  WIDTH  to RAM i_wr_data
o_ram_rd_en  out  1  to RAM i_rd_en
o_ram_rd_addr  out  $clog2(DEPTH)  to RAM i_rd_addr
i_ram_rd_data  in  WIDTH  from RAM o_rd_data

Behaviour:
- Reset (async assert, sync deassert handled upstream): wr_ptr=0, rd_ptr=0, count=0, o_rd_dv=0, o_overflow=0, o_underflow=0. Resulting outputs: o_empty=1, o_full=0, o_ae=1, o_af=(AF_LEVEL==0 ? 1 : 0), o_count=0.
- Write accept: wr_acc = i_wr_dv & ~o_full.
- Read accept: rd_acc = i_rd_en & ~o_empty.
- Both decisions use registered flags only; a same-cycle opposite operation never unblocks.
  - Write while full is rejected even if a read is accepted that cycle.
  - Read while empty is rejected even if a write is accepted that cycle.
- RAM drive (combinational from state and inputs):
  - o_ram_wr_dv = wr_acc; o_ram_wr_addr = wr_ptr; o_ram_wr_data = i_wr_data.
  - o_ram_rd_en = rd_acc; o_ram_rd_addr = rd_ptr.
- Pointers: +1 on accept. Width is $clog2(DEPTH), so they wrap DEPTH-1 -> 0 naturally.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- All flags are decoded from the registered count. A flag changes in the cycle after the accepting edge.
- Read latency: read accepted in cycle N -> o_rd_dv=1 and o_rd_data = entry at old rd_ptr in cycle N+1. o_rd_dv is registered from rd_acc.
- Write-to-read: write accepted in cycle N -> o_empty=0 in N+1 -> read accepted in N+1 -> data out in N+2. Minimum fall-through is 2 cycles.
- Full throughput: simultaneous accepted read and write every cycle sustains 1 word/cycle at any non-empty, non-full occupancy.
- Errors: o_overflow sets on i_wr_dv & o_full. o_underflow sets on i_rd_en & o_empty. Both clear only on reset. Rejected requests change no other state.
- Reset mid-operation:
  - State clears immediately and o_rd_dv drops asynchronously.
  - RAM contents are not cleared; they are unreachable because pointers are equal.
  - An in-flight read is discarded.
- o_rd_data is unspecified when o_rd_dv=0.

Test Plan:
- Reset, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 -> o_empty=1, o_ae=1, o_full=0, o_af=0, o_count=0, errors 0, o_rd_dv=0.
- Write 0x01..0x08, one per cycle, no reads -> o_count 1..8; o_af=1 from count 6; o_full=1 at count 8. A 9th write of 0xFF -> o_ram_wr_dv=0, o_overflow=1, count stays 8.
- Drain 8 reads -> o_rd_data 0x01..0x08 in order, each one cycle after its i_rd_en. Then o_empty=1; an extra i_rd_en -> o_ram_rd_en=0, o_underflow=1, no o_rd_dv.
- Wrap-around: write 5, read 5, write 6, read 6, with data 0x10+k -> pointers cross 7->0; read data matches write order; count returns to 0.
- Simultaneous: at count 3, assert i_wr_dv and i_rd_en for 10 cycles -> count stays 3; output sequence equals input delayed by 3 entries. At count 0 with both asserted -> write accepted, read rejected, o_underflow=1, count=1.
- Reset mid-burst: at count 5 with a read in flight, pulse i_rst_n low -> o_rd_dv=0 immediately, count=0, o_empty=1. Post-reset write 0xAA then read -> 0xAA.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM as a
// circular buffer. Owns the pointers, occupancy count, status and sticky
// error flags. Every flag is decoded from the registered count.
module ram_fifo_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_dv,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_dv,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_af,
    output logic                     o_ae,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic                     o_ram_wr_dv,
    output logic [$clog2(DEPTH)-1:0] o_ram_wr_addr,
    output logic [WIDTH-1:0]         o_ram_wr_data,
    output logic                     o_ram_rd_en,
    output logic [$clog2(DEPTH)-1:0] o_ram_rd_addr,
    input  logic [WIDTH-1:0]         i_ram_rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_dv;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [CW-1:0] w_count_d;

    // Status decode from the registered count, plus accept decisions that
    // look only at registered flags so an opposite operation never unblocks.
    always_comb begin
        w_full   = (r_count == LP_DEPTH);
        w_empty  = (r_count == '0);
        w_wr_acc = i_wr_dv & ~w_full;
        w_rd_acc = i_rd_en & ~w_empty;
    end

    // Occupancy next-state: unchanged when both or neither side accepts.
    always_comb begin
        w_count_d = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    // Pointer, count, read-valid and sticky error state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_dv     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_d;
            // RAM read is registered, so data is valid the cycle after accept.
            r_rd_dv <= w_rd_acc;
            if (i_wr_dv & w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd_en & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Output and RAM port drive.
    always_comb begin
        o_full        = w_full;
        o_empty       = w_empty;
        o_af          = (r_count >= LP_AF);
        o_ae          = (r_count <= LP_AE);
        o_count       = r_count;
        o_overflow    = r_overflow;
        o_underflow   = r_underflow;
        o_rd_dv       = r_rd_dv;
        o_rd_data     = i_ram_rd_data;
        o_ram_wr_dv   = w_wr_acc;
        o_ram_wr_addr = r_wr_ptr;
        o_ram_wr_data = i_wr_data;
        o_ram_rd_en   = w_rd_acc;
        o_ram_rd_addr = r_rd_ptr;
    end

endmodule
